// File: rtl/forward_scoreboard_pkg.sv
// Shared types for the forwarding/hazard scoreboard.
// Entry layout, forward-select width helper and stage index names.
package scoreboard_pkg;

    localparam int SB_EX  = 0;
    localparam int SB_MEM = 1;
    localparam int SB_WB  = 2;

    // Destination field is sized for the widest register file we expect (REGW <= 8)
    localparam int SB_WSEL_W = 8;

    typedef struct packed {
        logic                 valid;
        logic                 is_load;
        logic [SB_WSEL_W-1:0] wsel;
    } sb_entry_t;

    function automatic int sb_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/forward_scoreboard_if.sv
// Decode-side bundle of the forwarding scoreboard.
// master = decode/datapath, slave = scoreboard.
interface forward_scoreboard_if
    import scoreboard_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int REGW   = 5,
    parameter int WORD_W = 32,
    parameter int SELW   = sb_sel_w(DEPTH)
);
    logic                          advance;
    logic                          squash;
    logic                          issue_valid;
    logic [REGW-1:0]               issue_rs;
    logic [REGW-1:0]               issue_rt;
    logic                          issue_uses_rs;
    logic                          issue_uses_rt;
    logic                          issue_regwr;
    logic                          issue_is_load;
    logic [REGW-1:0]               issue_wsel;
    logic [WORD_W-1:0]             rf_rdat1;
    logic [WORD_W-1:0]             rf_rdat2;
    logic [DEPTH-1:0][WORD_W-1:0]  stage_data;
    logic                          stall;
    logic [SELW-1:0]               fwd_sel_rs;
    logic [SELW-1:0]               fwd_sel_rt;
    logic [WORD_W-1:0]             fwd_rs;
    logic [WORD_W-1:0]             fwd_rt;

    modport master (
        output advance, squash, issue_valid,
        output issue_rs, issue_rt, issue_uses_rs, issue_uses_rt,
        output issue_regwr, issue_is_load, issue_wsel,
        output rf_rdat1, rf_rdat2, stage_data,
        input  stall, fwd_sel_rs, fwd_sel_rt, fwd_rs, fwd_rt
    );

    modport slave (
        input  advance, squash, issue_valid,
        input  issue_rs, issue_rt, issue_uses_rs, issue_uses_rt,
        input  issue_regwr, issue_is_load, issue_wsel,
        input  rf_rdat1, rf_rdat2, stage_data,
        output stall, fwd_sel_rs, fwd_sel_rt, fwd_rs, fwd_rt
    );
endinterface

// File: rtl/forward_scoreboard_sb_match.sv
// Priority match of one source select against the in-flight writers.
// Youngest (lowest index) matching entry wins.
module sb_match
    import scoreboard_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int REGW       = 5,
    parameter int LOAD_STAGE = SB_WB,
    parameter int SELW       = sb_sel_w(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] i_ent,
    input  logic [REGW-1:0]       i_sel,
    input  logic                  i_use,
    output logic                  o_hit,
    output logic [SELW-1:0]       o_idx,
    output logic                  o_hazard
);
    logic w_load;

    always_comb begin
        o_hit    = 1'b0;
        o_idx    = '0;
        w_load   = 1'b0;
        o_hazard = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i_ent[i].valid && (i_ent[i].wsel == SB_WSEL_W'(i_sel)) &&
                (i_sel != '0) && i_use) begin
                o_hit  = 1'b1;
                o_idx  = SELW'(i);
                w_load = i_ent[i].is_load;
            end
        end
        o_hazard = o_hit && w_load && (int'(o_idx) < LOAD_STAGE);
    end
endmodule

// File: rtl/forward_scoreboard.sv
// Hazard/forwarding scoreboard at the decode/execute boundary.
// Define SCOREBOARD_STATS_EN to add the saturating stall_count output.
module forward_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int REGW       = 5,
    parameter int WORD_W     = 32,
    parameter int LOAD_STAGE = SB_WB,
    parameter int SELW       = sb_sel_w(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    forward_scoreboard_if.slave   sb
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]           stall_count
`endif
);
    sb_entry_t [DEPTH-1:0] r_ent;
    sb_entry_t             w_new;
    logic                  w_ins;
    logic                  w_stall;
    logic                  w_hit_rs, w_hit_rt;
    logic                  w_haz_rs, w_haz_rt;
    logic [SELW-1:0]       w_idx_rs, w_idx_rt;

    sb_match #(
        .DEPTH(DEPTH), .REGW(REGW), .LOAD_STAGE(LOAD_STAGE), .SELW(SELW)
    ) u_match_rs (
        .i_ent(r_ent), .i_sel(sb.issue_rs), .i_use(sb.issue_uses_rs),
        .o_hit(w_hit_rs), .o_idx(w_idx_rs), .o_hazard(w_haz_rs)
    );

    sb_match #(
        .DEPTH(DEPTH), .REGW(REGW), .LOAD_STAGE(LOAD_STAGE), .SELW(SELW)
    ) u_match_rt (
        .i_ent(r_ent), .i_sel(sb.issue_rt), .i_use(sb.issue_uses_rt),
        .o_hit(w_hit_rt), .o_idx(w_idx_rt), .o_hazard(w_haz_rt)
    );

    // Squash overrides stall: the flushed instruction must not hold decode
    assign w_stall = sb.issue_valid && !sb.squash && (w_haz_rs || w_haz_rt);
    assign w_ins   = sb.issue_valid && sb.issue_regwr &&
                     (sb.issue_wsel != '0) && !w_stall && !sb.squash;
    assign w_new   = '{valid: 1'b1, is_load: sb.issue_is_load,
                       wsel: SB_WSEL_W'(sb.issue_wsel)};
    assign sb.stall = w_stall;

    always_comb begin
        sb.fwd_sel_rs = w_hit_rs ? w_idx_rs + SELW'(1) : '0;
        sb.fwd_sel_rt = w_hit_rt ? w_idx_rt + SELW'(1) : '0;
        sb.fwd_rs     = sb.rf_rdat1;
        sb.fwd_rt     = sb.rf_rdat2;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_hit_rs && (w_idx_rs == SELW'(i)))
                sb.fwd_rs = sb.stage_data[i];
            if (w_hit_rt && (w_idx_rt == SELW'(i)))
                sb.fwd_rt = sb.stage_data[i];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ent <= '0;
        end else if (sb.advance) begin
            for (int i = 1; i < DEPTH; i++)
                r_ent[i] <= r_ent[i-1];
            r_ent[SB_EX] <= w_ins ? w_new : '0;
        end
    end

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_stall_cnt <= '0;
        else if (sb.advance && w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_count = r_stall_cnt;
`endif

endmodule
